// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 1W/2R register file with post-reset clear sequence; optional write-through bypass under REGFILE_BYPASS_EN
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] reg_file [DEPTH];

    logic              wr_r0;
    logic              rd1_r0;
    logic              rd2_r0;

    assign wr_r0  = (R0_ZERO != 0) && (WriteReg == '0);
    assign rd1_r0 = (R0_ZERO != 0) && (ReadReg1 == '0);
    assign rd2_r0 = (R0_ZERO != 0) && (ReadReg2 == '0);

    // ready is a decode of the registered state, so it only moves on clock edges
    assign ready = (state == RUN);

    // State and clear-counter registers; reset always restarts the clear pass from index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Next state and write-port steering: CLEAR owns the write port, user writes are dropped
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        wr_en        = 1'b0;
        wr_addr      = WriteReg;
        wr_data      = WriteData;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_idx;
                wr_data = '0;
                // terminal count checked before increment so the counter never wraps
                if (clr_idx == LAST_IDX) begin
                    state_next = RUN;
                end else begin
                    clr_idx_next = clr_idx + 1'b1;
                end
            end
            RUN: begin
                wr_en = WE && !wr_r0;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    // Register array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            reg_file[wr_addr] <= wr_data;
        end
    end

    // Read port 1: stored value, optional forward, then zero forcing for r0 and not-ready
    always_comb begin
        ReadData1 = reg_file[ReadReg1];
`ifdef REGFILE_BYPASS_EN
        if (ready && WE && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
`endif
        if (rd1_r0 || rst || !ready) begin
            ReadData1 = '0;
        end
    end

    // Read port 2: same structure as port 1
    always_comb begin
        ReadData2 = reg_file[ReadReg2];
`ifdef REGFILE_BYPASS_EN
        if (ready && WE && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
`endif
        if (rd2_r0 || rst || !ready) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the single-cycle MIPS register file: a 1-write / 2-read register array with configurable data width and depth, optional hardwired-zero register 0, and a hardware clear sequence after reset. Sits in the decode stage of single-cycle and pipelined datapaths. A `ready` flag gates the rest of the core until every register reads zero.

## Interface
Parameters:
- `DATA_W`, 32, width of each register in bits.
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` registers.
- `R0_ZERO`, 1, when 1: register 0 reads 0 and ignores writes. When 0: register 0 is an ordinary register.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `WE`  in  1  write enable.
- `WriteReg`  in  ADDR_W  write address.
- `WriteData`  in  DATA_W  write data.
- `ReadReg1`  in  ADDR_W  read port 1 address.
- `ReadReg2`  in  ADDR_W  read port 2 address.
- `ReadData1`  out  DATA_W  read port 1 data (combinational).
- `ReadData2`  out  DATA_W  read port 2 data (combinational).
- `ready`  out  1  high once the clear sequence has finished.

## Operation
- FSM states: CLEAR and RUN.
- Reset:
  - state = CLEAR, clear counter `clr_idx` = 0, `ready` = 0.
  - `ReadData1`/`ReadData2` read 0 while `rst` is high and throughout CLEAR.
- CLEAR:
  - Each cycle writes 0 to `regFile[clr_idx]`, then increments `clr_idx`.
  - The cycle that clears `clr_idx == DEPTH-1` moves to RUN.
  - `WE` is ignored for the whole state; there is no queueing and the write is lost.
- RUN:
  - `ready` = 1.
  - On a rising edge with `WE`=1, `regFile[WriteReg] <= WriteData`.
  - Exception: when `R0_ZERO`=1 and `WriteReg`=0, the write is dropped.
- Reads:
  - `ReadDataN = regFile[ReadRegN]`, asynchronous.
  - When `R0_ZERO`=1 and `ReadRegN`=0, the output is forced to 0.
- Both read ports may address the same register and return identical data.
- Asserting `rst` mid-RUN or mid-CLEAR restarts CLEAR from `clr_idx` = 0. All prior contents are lost.
- `clr_idx` is ADDR_W bits wide. The terminal count is detected before wrap, so the counter never wraps into a second pass.

## Timing
- Clear latency: `ready` rises on the edge DEPTH cycles after the first edge with `rst` low.
  - Defaults (DEPTH=32): the first write is accepted 32 cycles after reset release.
- Write-to-read: a write on edge N is visible on the combinational read outputs after edge N (zero-cycle read latency, one-edge write latency).
- Same-cycle write and read of one address: without bypass, the read returns the old value until the edge.
- `ready` is registered and changes only on clock edges.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - Write-through forwarding. When `ready`=1, `WE`=1 and `ReadRegN == WriteReg`, `ReadDataN = WriteData` in the same cycle.
  - The bypass is suppressed for register 0 when `R0_ZERO`=1.
  - This resolves a WB→ID hazard in the pipelined core without a half-cycle-write clock.
- Not defined:
  - No forwarding. Reads return the stored value; the new value appears after the edge.
- Neither setting changes the CLEAR behaviour.

## Test plan
- **Reset/clear:** pulse `rst` for 2 cycles, then hold `WE`=1, `WriteReg`=5, `WriteData`=0xDEADBEEF throughout.
  - `ready`=0 for exactly 32 cycles, then 1.
  - Register 5 reads 0xDEADBEEF only after the first RUN-cycle edge.
  - No CLEAR-cycle write is retained.
- **Basic write/read:** in RUN, write 0x12345678 to r7 and 0xCAFEF00D to r31, then read r7 on port 1 and r31 on port 2.
  - Ports return 0x12345678 and 0xCAFEF00D.
- **Zero register:** `R0_ZERO`=1, write 0xFFFFFFFF to r0.
  - Both ports read 0 at r0.
  - Repeat with `R0_ZERO`=0: r0 reads 0xFFFFFFFF.
- **Reset mid-operation:** write 0xA5A5A5A5 to r3, assert `rst` for 1 cycle.
  - `ready` drops the next edge.
  - r3 reads 0 during and after the new CLEAR.
  - `ready` returns after 32 cycles.
- **Bypass:** write 0x00000055 to r9 while `ReadReg1`=9 in the same cycle.
  - With `REGFILE_BYPASS_EN`: `ReadData1`=0x55 before the edge.
  - Without: the old value (0) before the edge and 0x55 after.
- **Parameter sweep:** `DATA_W`=16, `ADDR_W`=3.
  - `ready` rises 8 cycles after reset release.
  - A write of 0xBEEF to r7 reads back 0xBEEF.
